// File: rtl/sram_rd_arbiter.sv
// Round-robin read arbiter in front of one packet SRAM: grants one port per
// page burst of 8 beats and returns tagged read data after the SRAM latency.
module sram_rd_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int PAGE_W    = 11,
    parameter int SRAM_LAT  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS-1:0]             req,
    input  logic [NUM_PORTS-1:0][PAGE_W-1:0] req_page,
    output logic [NUM_PORTS-1:0]             grant,
    output logic                             busy,
    output logic                             sram_rd_en,
    output logic [PAGE_W+2:0]                sram_rd_addr,
    input  logic [15:0]                      sram_dout,
    output logic                             out_vld,
    output logic [3:0]                       out_port,
    output logic [15:0]                      out_data,
    output logic                             out_first,
    output logic                             out_last
);

    logic [2:0]                beat_q, beat_d;
    logic [3:0]                rr_ptr_q, rr_ptr_d;
    logic [3:0]                cur_port_q, cur_port_d;
    logic [PAGE_W-1:0]         cur_page_q, cur_page_d;
    logic [NUM_PORTS-1:0]      grant_q, grant_d;
    logic                      busy_q, busy_d;
    logic                      rd_en_q, rd_en_d;
    logic [PAGE_W+2:0]         rd_addr_q, rd_addr_d;
    logic [SRAM_LAT:0]         pvld_q, pvld_d;
    logic [SRAM_LAT:0]         pfirst_q, pfirst_d;
    logic [SRAM_LAT:0]         plast_q, plast_d;
    logic [SRAM_LAT:0][3:0]    pport_q, pport_d;
    logic [15:0]               out_data_q, out_data_d;
    logic                      found_s;
    logic [3:0]                winner_s;

    // Round-robin search: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found_s  = 1'b0;
        winner_s = 4'd0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_s && req[(int'(rr_ptr_q) + i) % NUM_PORTS]) begin
                found_s  = 1'b1;
                winner_s = 4'((int'(rr_ptr_q) + i) % NUM_PORTS);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Arbitration on beat 0, otherwise continue issuing the current page.
    always_comb begin
        beat_d     = beat_q;
        rr_ptr_d   = rr_ptr_q;
        cur_port_d = cur_port_q;
        cur_page_d = cur_page_q;
        grant_d    = '0;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        if (beat_q == 3'd0) begin
            if (found_s) begin
                grant_d    = {{(NUM_PORTS-1){1'b0}}, 1'b1} << winner_s;
                cur_port_d = winner_s;
                cur_page_d = req_page[winner_s];
                rd_en_d    = 1'b1;
                rd_addr_d  = {req_page[winner_s], 3'd0};
                beat_d     = 3'd1;
                rr_ptr_d   = (int'(winner_s) == NUM_PORTS - 1) ? 4'd0 : winner_s + 4'd1;
            end else begin
                grant_d    = '0;
                rd_en_d    = 1'b0;
            end
        end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = {cur_page_q, beat_q};
            beat_d    = beat_q + 3'd1;
        end
        // busy spans every issue cycle of the page, including beat 7.
        busy_d = rd_en_d;
    end

    // Return pipeline: tag each issued beat and align it to the SRAM data.
    always_comb begin
        pvld_d[0]   = rd_en_q;
        pport_d[0]  = cur_port_q;
        pfirst_d[0] = (rd_addr_q[2:0] == 3'd0);
        plast_d[0]  = (rd_addr_q[2:0] == 3'd7);
        for (int i = 1; i <= SRAM_LAT; i++) begin
            pvld_d[i]   = pvld_q[i-1];
            pport_d[i]  = pport_q[i-1];
            pfirst_d[i] = pfirst_q[i-1];
            plast_d[i]  = plast_q[i-1];
        end
        if (pvld_d[SRAM_LAT]) begin
            out_data_d = sram_dout;
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q     <= 3'd0;
            rr_ptr_q   <= 4'd0;
            cur_port_q <= 4'd0;
            cur_page_q <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            pvld_q     <= '0;
            pfirst_q   <= '0;
            plast_q    <= '0;
            pport_q    <= '0;
            out_data_q <= 16'd0;
        end else begin
            beat_q     <= beat_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_port_q <= cur_port_d;
            cur_page_q <= cur_page_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            pvld_q     <= pvld_d;
            pfirst_q   <= pfirst_d;
            plast_q    <= plast_d;
            pport_q    <= pport_d;
            out_data_q <= out_data_d;
        end
    end

    assign grant        = grant_q;
    assign busy         = busy_q;
    assign sram_rd_en   = rd_en_q;
    assign sram_rd_addr = rd_addr_q;
    assign out_vld      = pvld_q[SRAM_LAT];
    assign out_port     = pport_q[SRAM_LAT];
    assign out_first    = pfirst_q[SRAM_LAT];
    assign out_last     = plast_q[SRAM_LAT];
    assign out_data     = out_data_q;

endmodule
